// File: rtl/block_stream_emitter_pkg.sv
// block_stream_emitter_pkg: command encodings, FSM states and keyword constants
// shared by the emitter and its keyword ROM.
package block_stream_emitter_pkg;

    localparam logic [1:0] CMD_BEGIN     = 2'b00;
    localparam logic [1:0] CMD_END       = 2'b01;
    localparam logic [1:0] CMD_FILLER    = 2'b10;
    localparam logic [1:0] CMD_CLOSE_ALL = 2'b11;

    typedef enum logic [1:0] {IDLE, CHAR, SEP, CLOSE} state_e;

    localparam logic [39:0] KW_BEGIN  = "begin";
    localparam logic [23:0] KW_END    = "end";
    localparam logic [7:0]  KW_FILLER = "x";
    localparam logic [7:0]  CH_SPACE  = 8'h20;

    localparam logic [2:0] LEN_BEGIN  = 3'd5;
    localparam logic [2:0] LEN_END    = 3'd3;
    localparam logic [2:0] LEN_FILLER = 3'd1;

    function automatic logic [7:0] ascii_case(input logic [7:0] c, input bit upper);
        return upper ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/block_keyword_rom.sv
// block_keyword_rom: combinational lookup of keyword character idx_i for a command,
// with a flag marking the final keyword character. CLOSE_ALL spells "end".
module block_keyword_rom
    import block_stream_emitter_pkg::*;
#(
    parameter bit UPPER = 1'b0
) (
    input  logic [1:0] cmd_i,
    input  logic [2:0] idx_i,
    output logic [7:0] char_o,
    output logic       last_o
);

    logic [39:0] word;
    logic [2:0]  len;
    logic [2:0]  pos;

    // Keywords are right-aligned in word, so character idx sits (len-1-idx) bytes up.
    always_comb begin
        word   = cmd_i == CMD_BEGIN ? KW_BEGIN : cmd_i == CMD_FILLER ? {32'd0, KW_FILLER} : {16'd0, KW_END};
        len    = cmd_i == CMD_BEGIN ? LEN_BEGIN : cmd_i == CMD_FILLER ? LEN_FILLER : LEN_END;
        pos    = len - idx_i - 3'd1;
        char_o = ascii_case(8'(word >> {pos, 3'b000}), UPPER);
        last_o = idx_i == len - 3'd1;
    end

endmodule

// File: rtl/block_stream_emitter.sv
// block_stream_emitter: turns begin/end/filler/close-all commands into a balanced
// ASCII keyword stream. Define BLOCK_EMIT_UNBAL_EN to allow END at depth 0.
module block_stream_emitter
    import block_stream_emitter_pkg::*;
#(
    parameter int DEPTH_W = 4,
    parameter bit UPPER   = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic [7:0]         out_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               cmd_err,
    output logic               cmd_done
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               unbal_q, unbal_d;
    logic [7:0]         rom_char;
    logic               rom_last;
    logic               accept;
    logic               hs;

    block_keyword_rom #(.UPPER(UPPER)) u_rom (
        .cmd_i  (cmd_q),
        .idx_i  (idx_q),
        .char_o (rom_char),
        .last_o (rom_last)
    );

    assign cmd_ready = state_q == IDLE;
    assign out_valid = state_q == CHAR || state_q == SEP;
    assign out_char  = state_q == CHAR ? rom_char : state_q == SEP ? CH_SPACE : 8'h00;
    assign depth     = depth_q;
    assign balanced  = depth_q == '0 && !unbal_q;
    assign accept    = cmd_valid && cmd_ready;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        depth_d  = depth_q;
        unbal_d  = unbal_q;
        cmd_err  = 1'b0;
        cmd_done = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                cmd_d = cmd;
                idx_d = 3'd0;
                unique case (cmd)
                    CMD_BEGIN: begin
                        cmd_err = depth_q == DEPTH_MAX;
                        depth_d = cmd_err ? depth_q : depth_q + DEPTH_ONE;
                        state_d = cmd_err ? IDLE : CHAR;
                    end
                    CMD_END: begin
`ifdef BLOCK_EMIT_UNBAL_EN
                        unbal_d = unbal_q || depth_q == '0;
                        depth_d = depth_q == '0 ? depth_q : depth_q - DEPTH_ONE;
                        state_d = CHAR;
`else
                        cmd_err = depth_q == '0;
                        depth_d = cmd_err ? depth_q : depth_q - DEPTH_ONE;
                        state_d = cmd_err ? IDLE : CHAR;
`endif
                    end
                    CMD_FILLER: state_d = CHAR;
                    default:    state_d = depth_q == '0 ? CLOSE : CHAR;
                endcase
            end
            CHAR: if (hs) begin
                state_d = rom_last ? SEP : CHAR;
                idx_d   = rom_last ? idx_q : idx_q + 3'd1;
            end
            // Close-all chains the next "end " straight off the space handshake.
            SEP: if (hs) begin
                if (cmd_q == CMD_CLOSE_ALL) begin
                    depth_d  = depth_q - DEPTH_ONE;
                    cmd_done = depth_q == DEPTH_ONE;
                    state_d  = cmd_done ? IDLE : CHAR;
                    idx_d    = 3'd0;
                end else begin
                    cmd_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            CLOSE: begin
                cmd_done = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cmd_q   <= CMD_BEGIN;
            depth_q <= '0;
            unbal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            depth_q <= depth_d;
            unbal_q <= unbal_d;
        end
    end

endmodule

// File: tb/tb_block_stream_emitter.sv
// tb_block_stream_emitter: directed and randomized commands checked against a
// string-level model of the expected character stream and nesting depth.
module tb_block_stream_emitter;
    import block_stream_emitter_pkg::*;

    localparam int DEPTH_W = 4;
    localparam int MAXD    = 15;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd = 2'b00;
    logic               out_ready = 1'b0;
    logic               cmd_ready;
    logic [7:0]         out_char;
    logic               out_valid;
    logic [DEPTH_W-1:0] depth;
    logic               balanced;
    logic               cmd_err;
    logic               cmd_done;

    int passes = 0;
    int total  = 0;
    int md     = 0;
    bit unbal  = 1'b0;

    block_stream_emitter #(.DEPTH_W(DEPTH_W), .UPPER(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .depth     (depth),
        .balanced  (balanced),
        .cmd_err   (cmd_err),
        .cmd_done  (cmd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_cmd(input logic [1:0] c, input bit rnd);
        string s;
        bit    err;
        int    n;
        int    cyc;
        int    cur;
        s   = "";
        err = 1'b0;
        case (c)
            CMD_BEGIN: if (md == MAXD) err = 1'b1; else begin md++; s = "begin "; end
            CMD_END: if (md > 0) begin md--; s = "end "; end else begin
`ifdef BLOCK_EMIT_UNBAL_EN
                unbal = 1'b1;
                s = "end ";
`else
                err = 1'b1;
`endif
            end
            CMD_FILLER: s = "x ";
            default: for (int k = 0; k < md; k++) s = {s, "end "};
        endcase
        cur = md;
        @(negedge clk);
        out_ready = 1'b0;
        cmd = c;
        cmd_valid = 1'b1;
        #1;
        chk("ready_at_accept", cmd_ready, 1);
        chk("cmd_err_at_accept", cmd_err, err);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        if (err || s.len() == 0) begin
            chk("no_output", out_valid, 0);
            chk("depth_hold", depth, md);
            chk("done_after_empty", cmd_done, err ? 0 : 1);
            @(negedge clk);
            #1;
            chk("idle_after_empty", cmd_ready, 1);
            chk("done_single_pulse", cmd_done, 0);
            return;
        end
        n = 0;
        cyc = 0;
        while (n < s.len() && cyc < 400) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd = 2'($urandom_range(0, 3));
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_char", out_char, s[n]);
            chk("depth_busy", depth, cur);
            chk("busy_not_ready", cmd_ready, 0);
            chk("busy_no_err", cmd_err, 0);
            chk("cmd_done", cmd_done, out_ready && n == s.len() - 1);
            if (out_ready) begin
                if (c == CMD_CLOSE_ALL && s[n] == " ") cur--;
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        if (c == CMD_CLOSE_ALL) md = 0;
        chk("stream_complete", n, s.len());
        #1;
        chk("idle_after", cmd_ready, 1);
        chk("out_valid_low", out_valid, 0);
        chk("depth_after", depth, md);
        chk("balanced", balanced, md == 0 && !unbal);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_depth", depth, 0);
        chk("rst_balanced", balanced, 1);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_cmd_done", cmd_done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        run_cmd(CMD_BEGIN, 1'b0);
        run_cmd(CMD_END, 1'b0);
        repeat (3) run_cmd(CMD_BEGIN, 1'b0);
        run_cmd(CMD_CLOSE_ALL, 1'b0);
        run_cmd(CMD_END, 1'b0);
        run_cmd(CMD_CLOSE_ALL, 1'b0);
        run_cmd(CMD_BEGIN, 1'b1);
        run_cmd(CMD_FILLER, 1'b1);
        for (int i = 0; i < MAXD + 1; i++) run_cmd(CMD_BEGIN, 1'b0);
        run_cmd(CMD_CLOSE_ALL, 1'b1);

        // Reset while the third character of "begin" is on the bus.
        run_cmd(CMD_CLOSE_ALL, 1'b0);
        @(negedge clk);
        cmd = CMD_BEGIN;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("third_char", out_char, 8'h67);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        md = 0;
        unbal = 1'b0;
        run_cmd(CMD_FILLER, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            run_cmd(r < 4 ? CMD_BEGIN : r < 7 ? CMD_END : r < 9 ? CMD_FILLER : CMD_CLOSE_ALL, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
